wb_crc32: RTL and testbench

- Wishbone B4 pipelined slave computing a reflected CRC-32 (IEEE 802.3) over bytes written by the Ibex data port.
- Attaches as an additional slave port of the shared-bus interconnect, next to the single-port RAM.
- Offloads the CRC inner loop from software. Firmware streams words or bytes in and reads back the final CRC.

---
 rtl/wb_crc32.sv | 127 ++++++++++++
 tb/tb_wb_crc32.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_crc32.sv
// Wishbone B4 pipelined slave that folds written bytes into a reflected CRC-32.
// One byte lane is folded per cycle; the bus is stalled until every selected lane is consumed.
module wb_crc32 #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o
);

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_DATA   = 2'd1;
  localparam logic [1:0] ADR_RESULT = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  logic [31:0] crc_reg;
  logic [31:0] data_reg;
  logic [3:0]  pending_reg;
  logic        busy_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [31:0] dat_reg;

  logic [1:0]  lane_next;
  logic [3:0]  pending_next;
  logic [31:0] crc_next;
  logic        accept;
  logic        misaligned;
  logic        unused_ok;

  logic [7:0] lane_byte [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = data_reg[8*gi +: 8];
    end
  endgenerate

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  // Lowest-index pending lane is folded first, so sparse masks go in ascending order.
  always_comb begin
    lane_next = 2'd3;
    priority casez (pending_reg)
      4'b???1: lane_next = 2'd0;
      4'b??10: lane_next = 2'd1;
      4'b?100: lane_next = 2'd2;
      default: lane_next = 2'd3;
    endcase
    pending_next = pending_reg & ~(4'b0001 << lane_next);
    crc_next     = crc_byte(crc_reg, lane_byte[lane_next]);
  end

  assign accept     = wb_cyc_i & wb_stb_i & ~busy_reg;
  assign misaligned = |wb_adr_i[1:0];
  assign unused_ok  = ^wb_adr_i[31:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg     <= INIT;
      data_reg    <= '0;
      pending_reg <= '0;
      busy_reg    <= 1'b0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      dat_reg     <= '0;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      dat_reg <= '0;
      if (busy_reg) begin
        crc_reg     <= crc_next;
        pending_reg <= pending_next;
        busy_reg    <= |pending_next;
      end else if (accept) begin
        if (misaligned) begin
          err_reg <= 1'b1;
        end else begin
          ack_reg <= 1'b1;
          case (wb_adr_i[3:2])
            ADR_CTRL: begin
              if (wb_we_i && wb_dat_i[0]) crc_reg <= INIT;
            end
            ADR_DATA: begin
              if (wb_we_i) begin
                data_reg    <= wb_dat_i;
                pending_reg <= wb_sel_i;
                busy_reg    <= |wb_sel_i;
              end
            end
            ADR_RESULT: begin
              if (!wb_we_i) dat_reg <= crc_reg ^ XOROUT;
            end
            ADR_STATUS: begin
              if (!wb_we_i) dat_reg <= {31'b0, busy_reg};
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign wb_dat_o   = dat_reg;
  assign wb_ack_o   = ack_reg;
  assign wb_err_o   = err_reg;
  assign wb_stall_o = busy_reg;

endmodule

// File: tb/tb_wb_crc32.sv
// Bench for wb_crc32: byte-queue / table-driven CRC model checked every cycle, plus literal checks.
module tb_wb_crc32;

  localparam logic [31:0] POLY   = 32'hEDB88320;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] XOROUT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack, err, stall;

  int vectors = 0;
  int miscompares = 0;

  wb_crc32 #(.POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl [256];

  function automatic logic [31:0] fold(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] idx;
    idx = c[7:0] ^ b;
    return (c >> 8) ^ tbl[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Behavioural model: accepted bytes go into a queue, one is consumed per cycle.
  logic [31:0] m_crc;
  logic [7:0]  m_q [$];
  logic        m_ack, m_err, m_valid = 1'b0;
  logic [31:0] m_dat;

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      tbl[n] = c;
    end
  end

  initial forever begin
    @(posedge clk);
    m_ack = 1'b0;
    m_err = 1'b0;
    m_dat = '0;
    if (rst) begin
      m_crc = INIT;
      m_q.delete();
    end else if (m_q.size() != 0) begin
      m_crc = fold(m_crc, m_q.pop_front());
    end else if (cyc && stb) begin
      if (adr[1:0] != 2'd0) m_err = 1'b1;
      else begin
        m_ack = 1'b1;
        case (adr[3:2])
          2'd0: if (we && dat_i[0]) m_crc = INIT;
          2'd1: if (we) for (int i = 0; i < 4; i++) if (sel[i]) m_q.push_back(dat_i[8*i +: 8]);
          2'd2: if (!we) m_dat = m_crc ^ XOROUT;
          default: ;
        endcase
      end
    end
    m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("ack", {31'b0, ack}, {31'b0, m_ack});
      check("err", {31'b0, err}, {31'b0, m_err});
      check("stall", {31'b0, stall}, {31'b0, m_q.size() != 0});
      if (m_ack) check("rdata", dat_o, m_dat);
    end
  end

  // Called at a negedge; returns at the negedge where the response is visible, request still driven.
  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output int stalls, output logic got_err);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    stalls = 0;
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 40) check("stall_timeout", 32'(stalls), 32'd0);
    @(negedge clk);
    rd = dat_o;
    got_err = err;
    if (ack !== 1'b1 && err !== 1'b1) check("no_response", {30'b0, ack, err}, 32'd1);
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] bytes [$]);
    logic [31:0] c;
    c = INIT;
    foreach (bytes[i]) c = fold(c, bytes[i]);
    return c ^ XOROUT;
  endfunction

  logic [31:0] rd;
  int          st;
  logic        e;
  logic [7:0]  bq [$];

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_dat", dat_o, 32'd0);
    rst = 1'b0;

    // "123456789" one byte per write, lanes rotated
    for (int k = 0; k < 9; k++) begin
      logic [1:0] ln;
      ln = 2'(k % 4);
      req(1'b1, 32'h4, 4'b0001 << ln, 32'(8'h31 + k) << (8 * ln), rd, st, e);
      if (k > 0) check("byte_stall", 32'(st), 32'd1);
    end
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("check_value", rd, 32'hCBF43926);
    idle();

    // Misaligned access errors and leaves crc alone
    req(1'b0, 32'h2, 4'hF, 0, rd, st, e);
    check("misaligned_err", {31'b0, e}, 32'd1);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("crc_after_err", rd, 32'hCBF43926);
    req(1'b1, 32'h8, 4'hF, 32'h12345678, rd, st, e);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("crc_after_result_wr", rd, 32'hCBF43926);
    req(1'b1, 32'h4, 4'h0, 32'hDEADBEEF, rd, st, e);
    req(1'b0, 32'hC, 4'hF, 0, rd, st, e);
    check("sel0_no_stall", 32'(st), 32'd0);
    check("status_read", rd, 32'd0);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("crc_after_sel0", rd, 32'hCBF43926);
    idle();

    // Word writes
    req(1'b1, 32'h0, 4'hF, 32'h1, rd, st, e);
    req(1'b1, 32'h4, 4'hF, 32'h34333231, rd, st, e);
    req(1'b1, 32'h4, 4'hF, 32'h38373635, rd, st, e);
    check("word_stall_a", 32'(st), 32'd4);
    req(1'b1, 32'h4, 4'h1, 32'h00000039, rd, st, e);
    check("word_stall_b", 32'(st), 32'd4);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("word_result", rd, 32'hCBF43926);

    // Empty stream, then pipelined write->read
    req(1'b1, 32'h0, 4'hF, 32'h1, rd, st, e);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("empty_result", rd, 32'h00000000);
    req(1'b1, 32'h4, 4'h1, 32'h31, rd, st, e);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("pipe_stall", 32'(st), 32'd1);
    bq = '{8'h31};
    check("pipe_result", rd, ref_crc(bq));
    idle();

    // Sparse lanes
    req(1'b1, 32'h0, 4'hF, 32'h1, rd, st, e);
    req(1'b1, 32'h4, 4'b1010, 32'h39003100, rd, st, e);
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("sparse_stall", 32'(st), 32'd2);
    bq = '{8'h31, 8'h39};
    check("sparse_result", rd, ref_crc(bq));
    idle();

    // Reset during the second busy cycle of a 4-lane write
    req(1'b1, 32'h4, 4'hF, 32'hA5A5A5A5, rd, st, e);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_ack", {31'b0, ack}, 32'd0);
    rst = 1'b0;
    req(1'b0, 32'h8, 4'hF, 0, rd, st, e);
    check("rst_mid_result", rd, 32'h00000000);
    idle();

    // Randomized traffic; the per-cycle compare does the checking
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      a = a | ($urandom & 32'hFFFFFFF0);
      req(1'($urandom), a, 4'($urandom), (a[3:2] == 2'd0 && $urandom_range(0, 3) != 0) ? 32'd0 : $urandom,
          rd, st, e);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
